// File: rtl/data_table_ram_arb_pkg.sv
// Shared types for the data-table RAM arbiter: RAM word layout and arbiter FSM states.
package data_table_ram_arb_pkg;

    localparam int HEAD_PTR_WIDTH = 8;
    localparam int KEY_WIDTH      = 16;
    localparam int VALUE_WIDTH    = 16;

    // One hash-table data entry as stored in the data RAM.
    typedef struct packed {
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        logic [HEAD_PTR_WIDTH-1:0] next_ptr;
        logic                      next_ptr_val;
    } ram_data_t;

    // IDLE: free arbitration. LOCKED: a single engine owns both RAM ports.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } data_table_arb_state_t;

endpackage

// File: rtl/data_table_ram_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first masked requester at or after the
// pointer. The pick is only a candidate; the pointer moves past it when the
// parent confirms the grant via advance_i (a read may still lose to a write).
module rr_arbiter #(
    parameter int REQ_CNT = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [REQ_CNT-1:0] req_i,
    input  logic [REQ_CNT-1:0] mask_i,
    input  logic               advance_i,
    output logic [REQ_CNT-1:0] cand_o
);

    localparam int PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [REQ_CNT-1:0] w_req_m;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_found;
    logic [PTR_W:0]     w_scan;

    assign w_req_m = req_i & mask_i;

    // Scan requesters starting at the pointer, wrapping once around.
    always_comb begin
        cand_o    = '0;
        w_win_idx = r_ptr;
        w_found   = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(REQ_CNT)) begin
                w_scan = w_scan - (PTR_W+1)'(REQ_CNT);
            end
            if (!w_found && w_req_m[w_scan[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan[PTR_W-1:0];
            end
        end
        if (w_found) begin
            cand_o[w_win_idx] = 1'b1;
        end
    end

    // Pointer moves to one past the confirmed winner; holds otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= '0;
        end else if (advance_i && w_found) begin
            r_ptr <= (w_win_idx == PTR_W'(REQ_CNT-1)) ? '0 : w_win_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/data_table_ram_arb.sv
// Shares one data RAM (read port + write port) between REQ_CNT engines.
// Independent round-robin read/write arbitration, write wins on an address
// clash, per-engine lock for read-modify-write, tagged read-data return.
module data_table_ram_arb
    import data_table_ram_arb_pkg::*;
#(
    parameter int REQ_CNT     = 4,
    parameter int A_WIDTH     = HEAD_PTR_WIDTH,
    parameter int D_WIDTH     = $bits(ram_data_t),
    parameter int RAM_LATENCY = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [REQ_CNT-1:0]              rd_req_i,
    input  logic [REQ_CNT-1:0][A_WIDTH-1:0] rd_addr_i,
    output logic [REQ_CNT-1:0]              rd_gnt_o,
    output logic [D_WIDTH-1:0]              rd_data_o,
    output logic [REQ_CNT-1:0]              rd_data_val_o,
    input  logic [REQ_CNT-1:0]              wr_req_i,
    input  logic [REQ_CNT-1:0][A_WIDTH-1:0] wr_addr_i,
    input  logic [REQ_CNT-1:0][D_WIDTH-1:0] wr_data_i,
    output logic [REQ_CNT-1:0]              wr_gnt_o,
    input  logic [REQ_CNT-1:0]              lock_i,
    output logic [A_WIDTH-1:0]              ram_rd_addr_o,
    output logic                            ram_rd_en_o,
    input  logic [D_WIDTH-1:0]              ram_rd_data_i,
    output logic [A_WIDTH-1:0]              ram_wr_addr_o,
    output logic [D_WIDTH-1:0]              ram_wr_data_o,
    output logic                            ram_wr_en_o
);

    data_table_arb_state_t               r_state;
    logic [REQ_CNT-1:0]                  r_owner;
    logic [RAM_LATENCY-1:0][REQ_CNT-1:0] r_ret_pipe;

    logic [REQ_CNT-1:0]              w_mask;
    logic [REQ_CNT-1:0]              w_rd_cand;
    logic [REQ_CNT-1:0]              w_wr_cand;
    logic [REQ_CNT-1:0]              w_rd_gnt;
    logic [REQ_CNT-1:0]              w_wr_gnt;
    logic                            w_rd_adv;
    logic                            w_wr_adv;
    logic                            w_collision;
    logic [REQ_CNT-1:0][A_WIDTH-1:0] w_rd_addr_term;
    logic [REQ_CNT-1:0][A_WIDTH-1:0] w_wr_addr_term;
    logic [REQ_CNT-1:0][D_WIDTH-1:0] w_wr_data_term;
    logic [A_WIDTH-1:0]              w_rd_addr;
    logic [A_WIDTH-1:0]              w_wr_addr;
    logic [D_WIDTH-1:0]              w_wr_data;

    // While locked only the owner is visible to either arbiter.
    assign w_mask = (r_state == ARB_LOCKED) ? r_owner : {REQ_CNT{1'b1}};

    rr_arbiter #(.REQ_CNT(REQ_CNT)) u_rd_arb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (rd_req_i),
        .mask_i    (w_mask),
        .advance_i (w_rd_adv),
        .cand_o    (w_rd_cand)
    );

    rr_arbiter #(.REQ_CNT(REQ_CNT)) u_wr_arb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (wr_req_i),
        .mask_i    (w_mask),
        .advance_i (w_wr_adv),
        .cand_o    (w_wr_cand)
    );

    // AND-OR mux terms: only the candidate engine contributes, so an idle
    // port naturally drives zero address/data.
    genvar gi;
    generate
        for (gi = 0; gi < REQ_CNT; gi++) begin : g_mux_term
            assign w_rd_addr_term[gi] = rd_addr_i[gi] & {A_WIDTH{w_rd_cand[gi]}};
            assign w_wr_addr_term[gi] = wr_addr_i[gi] & {A_WIDTH{w_wr_cand[gi]}};
            assign w_wr_data_term[gi] = wr_data_i[gi] & {D_WIDTH{w_wr_cand[gi]}};
        end
    endgenerate

    // OR-reduce the mux terms into the candidate address/data.
    always_comb begin
        w_rd_addr = '0;
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            w_rd_addr = w_rd_addr | w_rd_addr_term[i];
            w_wr_addr = w_wr_addr | w_wr_addr_term[i];
            w_wr_data = w_wr_data | w_wr_data_term[i];
        end
    end

    // Same-address read/write in one cycle: the write goes first so the read
    // (retried next cycle) sees the new data.
    assign w_collision = (|w_rd_cand) && (|w_wr_cand) && (w_rd_addr == w_wr_addr);

    // Grants are forced low while reset is held.
    assign w_rd_gnt = w_collision ? '0 : (w_rd_cand & {REQ_CNT{rst_n_i}});
    assign w_wr_gnt = w_wr_cand & {REQ_CNT{rst_n_i}};
    assign w_rd_adv = |w_rd_gnt;
    assign w_wr_adv = |w_wr_gnt;

    assign rd_gnt_o      = w_rd_gnt;
    assign wr_gnt_o      = w_wr_gnt;
    assign ram_rd_en_o   = w_rd_adv;
    assign ram_wr_en_o   = w_wr_adv;
    assign ram_rd_addr_o = w_rd_adv ? w_rd_addr : '0;
    assign ram_wr_addr_o = w_wr_adv ? w_wr_addr : '0;
    assign ram_wr_data_o = w_wr_adv ? w_wr_data : '0;
    assign rd_data_o     = ram_rd_data_i;
    assign rd_data_val_o = r_ret_pipe[RAM_LATENCY-1];

    // Return tag pipe: the one-hot read grant travels alongside the RAM read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ret_pipe <= '0;
        end else begin
            r_ret_pipe[0] <= w_rd_gnt;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_ret_pipe[i] <= r_ret_pipe[i-1];
            end
        end
    end

    // Lock FSM: a locked grant captures ownership (read grant checked first);
    // the owner releases by dropping lock_i on a grant or while idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|(w_rd_gnt & lock_i)) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_rd_gnt;
                    end else if (|(w_wr_gnt & lock_i)) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_wr_gnt;
                    end
                end
                ARB_LOCKED: begin
                    if (!(|(lock_i & r_owner))) begin
                        if ((|((w_rd_gnt | w_wr_gnt) & r_owner)) ||
                            !(|((rd_req_i | wr_req_i) & r_owner))) begin
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
